// File: rtl/izh_pkg.sv
// rtl/izh_pkg.sv - shared types and widths for the Izhikevich step scheduler
package izh_pkg;

    localparam int IDX_W  = 10;
    localparam int ADDR_W = 20;
    localparam int LAT_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCUM  = 3'd1,
        S_UPDATE = 3'd2,
        S_DRAIN  = 3'd3,
        S_SWAP   = 3'd4,
        S_DONE   = 3'd5
    } izh_state_t;

    function automatic logic is_busy(izh_state_t s);
        return (s == S_ACCUM) || (s == S_UPDATE) || (s == S_DRAIN) || (s == S_SWAP);
    endfunction

endpackage

// File: rtl/izh_lat_counter.sv
// rtl/izh_lat_counter.sv - loadable down-counter with zero flag for the drain wait
module izh_lat_counter
    import izh_pkg::*;
#(
    parameter int W = LAT_W
) (
    input  logic         clk,
    input  logic         aclr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!aclr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/izh_step_scheduler.sv
// rtl/izh_step_scheduler.sv - per-timestep accumulate/update/drain/swap sequencer
// Optional stall input enabled by macro IZH_SCHED_STALL_EN.
module izh_step_scheduler
    import izh_pkg::*;
#(
    parameter int UPD_LAT = 3
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              start,
    input  logic [IDX_W-1:0]  size,
    input  logic [IDX_W-1:0]  timesteps,
`ifdef IZH_SCHED_STALL_EN
    input  logic              stall,
`endif
    output logic              wgt_rd_en,
    output logic [ADDR_W-1:0] wgt_addr,
    output logic [IDX_W-1:0]  spk_rd_addr,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              nrn_upd,
    output logic [IDX_W-1:0]  nrn_idx,
    output logic              spk_swap,
    output logic              busy,
    output logic              finished,
    output logic [IDX_W-1:0]  curTimestep
);

    izh_state_t        state, state_n;
    logic [IDX_W-1:0]  size_q, ts_q;
    logic [IDX_W-1:0]  t, i, j;
    logic [ADDR_W-1:0] addr;
    logic              hold;
    logic              drain_zero;
    logic              last_j, last_i, last_t;

    localparam logic [LAT_W-1:0] DRAIN_LOAD = LAT_W'(UPD_LAT - 1);

`ifdef IZH_SCHED_STALL_EN
    assign hold = stall && is_busy(state);
`else
    assign hold = 1'b0;
`endif

    assign last_j = (j == size_q - 1'b1);
    assign last_i = (i == size_q - 1'b1);
    assign last_t = (t == ts_q - 1'b1);

    always_ff @(posedge clk) begin
        if (!aclr) begin
            state  <= S_IDLE;
            size_q <= '0;
            ts_q   <= '0;
            t      <= '0;
            i      <= '0;
            j      <= '0;
            addr   <= '0;
        end else begin
            state <= state_n;
            if (!hold) begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            size_q <= size;
                            ts_q   <= timesteps;
                            t      <= '0;
                            i      <= '0;
                            j      <= '0;
                            addr   <= '0;
                        end
                    end
                    S_ACCUM: begin
                        j    <= j + 1'b1;
                        addr <= addr + 1'b1;
                    end
                    S_UPDATE: begin
                        j <= '0;
                        if (!last_i) begin
                            i <= i + 1'b1;
                        end
                    end
                    S_SWAP: begin
                        // The weight address restarts at row 0 for every new timestep.
                        addr <= '0;
                        i    <= '0;
                        if (!last_t) begin
                            t <= t + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_n = state;
        if (!hold) begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state_n = ((size == '0) || (timesteps == '0)) ? S_DONE : S_ACCUM;
                    end
                end
                S_ACCUM:  state_n = last_j ? S_UPDATE : S_ACCUM;
                S_UPDATE: state_n = last_i ? S_DRAIN : S_ACCUM;
                S_DRAIN:  state_n = drain_zero ? S_SWAP : S_DRAIN;
                S_SWAP:   state_n = last_t ? S_DONE : S_ACCUM;
                S_DONE:   state_n = start ? S_DONE : S_IDLE;
                default:  state_n = S_IDLE;
            endcase
        end
    end

    // Loaded on the final UPDATE so DRAIN lasts exactly UPD_LAT cycles.
    izh_lat_counter #(.W(LAT_W)) u_lat (
        .clk      (clk),
        .aclr     (aclr),
        .load     ((state == S_UPDATE) && last_i && !hold),
        .load_val (DRAIN_LOAD),
        .dec      ((state == S_DRAIN) && !hold),
        .zero     (drain_zero)
    );

    always_comb begin
        wgt_rd_en   = 1'b0;
        acc_en      = 1'b0;
        acc_clr     = 1'b0;
        spk_rd_addr = '0;
        nrn_upd     = 1'b0;
        nrn_idx     = '0;
        spk_swap    = 1'b0;
        if (!hold) begin
            unique case (state)
                S_ACCUM: begin
                    wgt_rd_en   = 1'b1;
                    acc_en      = 1'b1;
                    acc_clr     = (j == '0);
                    spk_rd_addr = j;
                end
                S_UPDATE: begin
                    nrn_upd = 1'b1;
                    nrn_idx = i;
                end
                S_SWAP:  spk_swap = 1'b1;
                default: ;
            endcase
        end
    end

    assign wgt_addr    = addr;
    assign busy        = is_busy(state);
    assign finished    = (state == S_DONE);
    assign curTimestep = t;

endmodule

// File: tb/tb_izh_step_scheduler.sv
// tb/tb_izh_step_scheduler.sv - randomized self-checking bench with trace reference model
module tb_izh_step_scheduler;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        aclr;
    logic        start;
    logic [9:0]  size, timesteps;
`ifdef IZH_SCHED_STALL_EN
    logic        stall;
`endif
    logic        wgt_rd_en, acc_clr, acc_en, nrn_upd, spk_swap, busy, finished;
    logic [19:0] wgt_addr;
    logic [9:0]  spk_rd_addr, nrn_idx, curTimestep;

    always #5 clk = ~clk;

    izh_step_scheduler #(.UPD_LAT(LAT)) dut (
        .clk         (clk),
        .aclr        (aclr),
        .start       (start),
        .size        (size),
        .timesteps   (timesteps),
`ifdef IZH_SCHED_STALL_EN
        .stall       (stall),
`endif
        .wgt_rd_en   (wgt_rd_en),
        .wgt_addr    (wgt_addr),
        .spk_rd_addr (spk_rd_addr),
        .acc_clr     (acc_clr),
        .acc_en      (acc_en),
        .nrn_upd     (nrn_upd),
        .nrn_idx     (nrn_idx),
        .spk_swap    (spk_swap),
        .busy        (busy),
        .finished    (finished),
        .curTimestep (curTimestep)
    );

    typedef struct packed {
        logic        busy, finished, rd, acc, clr, upd, swp;
        logic [19:0] addr;
        logic [9:0]  jj, ii, ts;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    function automatic obs_t mk(bit b, bit f, bit rd, bit clr, bit upd, bit swp,
                                int addr, int jj, int ii, int ts);
        obs_t o;
        o.busy = b; o.finished = f; o.rd = rd; o.acc = rd; o.clr = clr;
        o.upd = upd; o.swp = swp;
        o.addr = 20'(addr); o.jj = 10'(jj); o.ii = 10'(ii); o.ts = 10'(ts);
        return o;
    endfunction

    function automatic obs_t cur();
        obs_t o;
        o.busy = busy; o.finished = finished; o.rd = wgt_rd_en; o.acc = acc_en;
        o.clr = acc_clr; o.upd = nrn_upd; o.swp = spk_swap;
        o.addr = wgt_addr; o.jj = spk_rd_addr; o.ii = nrn_idx; o.ts = curTimestep;
        return o;
    endfunction

    // Expected cycle-by-cycle activity of one run: for each timestep, for each
    // neuron i, n weight reads of row i then one update; then LAT drain cycles and a swap.
    task automatic build(int n, int ts);
        exp_q.delete();
        if (n > 0 && ts > 0) begin
            for (int t = 0; t < ts; t++) begin
                for (int i = 0; i < n; i++) begin
                    for (int j = 0; j < n; j++)
                        exp_q.push_back(mk(1, 0, 1, j == 0, 0, 0, i * n + j, j, 0, t));
                    exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, i, t));
                end
                repeat (LAT) exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, t));
                exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, t));
            end
        end
    endtask

    task automatic check_cycle(string tag, obs_t e);
        obs_t o;
        o = cur();
        if (!e.rd) begin o.addr = '0; o.jj = '0; end
        if (!e.upd) o.ii = '0;
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic run(int n, int ts, bit scramble);
        int fin_t;
        fin_t = (n > 0 && ts > 0) ? ts - 1 : 0;
        build(n, ts);
        if (n > 0 && ts > 0)
            assert (exp_q.size() == ts * (n * (n + 1) + LAT + 1));
        @(negedge clk);
        size = 10'(n); timesteps = 10'(ts); start = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            check_cycle($sformatf("run_%0dx%0d_c%0d", n, ts, k + 1), exp_q[k]);
            if (scramble) begin
                size = 10'($urandom);
                timesteps = 10'($urandom);
                start = 1'($urandom);
            end
        end
        start = 1'b1;
        @(negedge clk);
        check_cycle($sformatf("done_%0dx%0d", n, ts), mk(0, 1, 0, 0, 0, 0, 0, 0, 0, fin_t));
        repeat (3) begin
            @(negedge clk);
            check_cycle("done_held", mk(0, 1, 0, 0, 0, 0, 0, 0, 0, fin_t));
        end
        start = 1'b0;
        @(negedge clk);
        check_cycle("idle_after_done", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, fin_t));
    endtask

    initial begin
        aclr = 1'b0; start = 1'b0; size = '0; timesteps = '0;
`ifdef IZH_SCHED_STALL_EN
        stall = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checks++;
        assert (cur() === '0) else begin
            failures++;
            $error("FAIL reset_state observed=%h expected=0", cur());
        end
        aclr = 1'b1;

        run(2, 1, 1'b0);
        run(3, 4, 1'b1);
        run(0, 3, 1'b0);
        run(3, 0, 1'b0);
        run(1, 2, 1'b1);
        for (int r = 0; r < 6; r++)
            run(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)), 1'b1);

        // Reset in the middle of timestep 2 accumulation.
        build(3, 4);
        @(negedge clk);
        size = 10'd3; timesteps = 10'd4; start = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            check_cycle($sformatf("pre_reset_c%0d", k + 1), exp_q[k]);
            if (exp_q[k].ts == 10'd2 && exp_q[k].rd && exp_q[k].jj == 10'd1) break;
        end
        aclr = 1'b0;
        @(negedge clk);
        checks++;
        assert (cur() === '0) else begin
            failures++;
            $error("FAIL mid_run_reset observed=%h expected=0", cur());
        end
        aclr = 1'b1; start = 1'b0;
        @(negedge clk);
        check_cycle("post_reset_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run(2, 1, 1'b0);

`ifdef IZH_SCHED_STALL_EN
        begin
            int cyc;
            @(negedge clk);
            size = 10'd2; timesteps = 10'd1; start = 1'b1;
            @(negedge clk);
            check_cycle("stall_first", mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
            stall = 1'b1;
            for (int s = 0; s < 5; s++) begin
                @(negedge clk);
                check_cycle($sformatf("stall_hold_%0d", s), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                checks++;
                assert (wgt_addr === 20'd0) else begin
                    failures++;
                    $error("FAIL stall_addr observed=%0d expected=0", wgt_addr);
                end
            end
            stall = 1'b0;
            cyc = 6;
            while (!finished && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            checks++;
            assert (cyc === 16) else begin
                failures++;
                $error("FAIL stall_latency observed=%0d expected=16", cyc);
            end
            start = 1'b0;
            @(negedge clk);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
